fwd_value_pipe: RTL and testbench

Datapath partner of the forwarding unit: it holds the destination register and result value of the last three issued instructions (PC-4, PC-8, PC-12 slots) and resolves the forwarding unit's 2-bit select lines into actual 32-bit operands for EXE and for the decode-stage branch/JR compare. It tracks loads whose data is not yet returned, and raises a load-use stall when a select points at such a slot. It sits between the register file read ports, the EXE/MEM result buses and the EXE/branch operand muxes.

---
 rtl/fwd_value_pipe.sv | 138 +++++++++++++
 tb/tb_fwd_value_pipe.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fwd_value_pipe.sv
// Forwarding datapath: three-deep history of issued results, with a patch path for returning
// load data, resolving the 2-bit forward selects into operands and raising a load-use stall.

module fwd_opnd_mux #(
  parameter int DEPTH = 3,
  parameter int DW    = 32
) (
  input  logic [1:0]                sel,
  input  logic [DW-1:0]             reg_in,
  input  logic [DEPTH:1][4:0]       s_reg,
  input  logic [DEPTH:1][DW-1:0]    s_data,
  input  logic [DEPTH:1]            s_pend,
  output logic [DW-1:0]             val,
  output logic                      stall
);
  always_comb begin
    val   = reg_in;
    stall = 1'b0;
    // r0 is hardwired zero in the register file, so it is never forwarded
    if (sel != 2'd0 && s_reg[sel] != 5'd0) begin
      val   = s_data[sel];
      stall = s_pend[sel];
    end
  end
endmodule

module fwd_value_pipe #(
  parameter int DEPTH = 3,
  parameter int DW    = 32
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          advance,
  input  logic          flush,
  input  logic          result_valid,
  input  logic [4:0]    result_reg,
  input  logic [DW-1:0] result_data,
  input  logic          result_is_load,
  input  logic          load_data_valid,
  input  logic [DW-1:0] load_data,
  input  logic [1:0]    EXE_A_Select,
  input  logic [1:0]    EXE_B_Select,
  input  logic [1:0]    Branch_JR_select_A,
  input  logic [1:0]    Branch_JR_select_B,
  input  logic [DW-1:0] regA_in,
  input  logic [DW-1:0] regB_in,
  output logic [DW-1:0] exe_a,
  output logic [DW-1:0] exe_b,
  output logic [DW-1:0] br_a,
  output logic [DW-1:0] br_b,
  output logic          load_use_stall
);
  localparam int NUM_OPND = 4;

  typedef struct packed {
    logic [4:0]    rg;
    logic [DW-1:0] data;
    logic          pend;
  } slot_t;

  slot_t slot_q [1:DEPTH];
  slot_t slot1_p;
  slot_t new_e;

  // Slot 1 as seen this cycle, with any returning load data already merged in
  always_comb begin
    slot1_p = slot_q[1];
    if (load_data_valid && slot_q[1].pend) begin
      slot1_p.data = load_data;
      slot1_p.pend = 1'b0;
    end
  end

  always_comb begin
    new_e = '0;
    if (!flush) begin
      new_e.rg   = result_valid ? result_reg : 5'd0;
      new_e.data = result_data;
      new_e.pend = result_valid & result_is_load;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int k = 1; k <= DEPTH; k++) slot_q[k] <= '0;
    end else if (advance) begin
      for (int k = DEPTH; k > 2; k--) slot_q[k] <= slot_q[k-1];
      slot_q[2] <= slot1_p;
      slot_q[1] <= new_e;
    end else begin
      slot_q[1] <= slot1_p;
    end
  end

  logic [DEPTH:1][4:0]    s_reg;
  logic [DEPTH:1][DW-1:0] s_data;
  logic [DEPTH:1]         s_pend;

  always_comb begin
    s_reg[1]  = slot1_p.rg;
    s_data[1] = slot1_p.data;
    s_pend[1] = slot1_p.pend;
    for (int k = 2; k <= DEPTH; k++) begin
      s_reg[k]  = slot_q[k].rg;
      s_data[k] = slot_q[k].data;
      s_pend[k] = slot_q[k].pend;
    end
  end

  logic [NUM_OPND-1:0][1:0]    sel_vec;
  logic [NUM_OPND-1:0][DW-1:0] rin_vec;
  logic [NUM_OPND-1:0][DW-1:0] out_vec;
  logic [NUM_OPND-1:0]         stall_vec;

  assign sel_vec = {Branch_JR_select_B, Branch_JR_select_A, EXE_B_Select, EXE_A_Select};
  assign rin_vec = {regB_in, regA_in, regB_in, regA_in};

  genvar g;
  generate
    for (g = 0; g < NUM_OPND; g++) begin : g_mux
      fwd_opnd_mux #(.DEPTH(DEPTH), .DW(DW)) u_mux (
        .sel    (sel_vec[g]),
        .reg_in (rin_vec[g]),
        .s_reg  (s_reg),
        .s_data (s_data),
        .s_pend (s_pend),
        .val    (out_vec[g]),
        .stall  (stall_vec[g])
      );
    end
  endgenerate

  assign exe_a          = out_vec[0];
  assign exe_b          = out_vec[1];
  assign br_a           = out_vec[2];
  assign br_b           = out_vec[3];
  assign load_use_stall = |stall_vec;
endmodule

// File: tb/tb_fwd_value_pipe.sv
// Directed bench for fwd_value_pipe: hand-computed operands and stall through a fixed sequence.

module tb_fwd_value_pipe;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        advance, flush;
  logic        result_valid, result_is_load, load_data_valid;
  logic [4:0]  result_reg;
  logic [31:0] result_data, load_data, regA_in, regB_in;
  logic [1:0]  EXE_A_Select, EXE_B_Select, Branch_JR_select_A, Branch_JR_select_B;
  logic [31:0] exe_a, exe_b, br_a, br_b;
  logic        load_use_stall;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  fwd_value_pipe #(.DEPTH(3), .DW(32)) dut (
    .CLK(CLK), .RESET(RESET), .advance(advance), .flush(flush),
    .result_valid(result_valid), .result_reg(result_reg), .result_data(result_data),
    .result_is_load(result_is_load), .load_data_valid(load_data_valid), .load_data(load_data),
    .EXE_A_Select(EXE_A_Select), .EXE_B_Select(EXE_B_Select),
    .Branch_JR_select_A(Branch_JR_select_A), .Branch_JR_select_B(Branch_JR_select_B),
    .regA_in(regA_in), .regB_in(regB_in),
    .exe_a(exe_a), .exe_b(exe_b), .br_a(br_a), .br_b(br_b),
    .load_use_stall(load_use_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; advance = 0; flush = 0;
    result_valid = 0; result_is_load = 0; result_reg = 0; result_data = 0;
    load_data_valid = 0; load_data = 0;
    EXE_A_Select = 1; EXE_B_Select = 1; Branch_JR_select_A = 1; Branch_JR_select_B = 1;
    regA_in = 32'h11; regB_in = 32'h22;
    #3;
    chk("rst_exe_a", exe_a, 32'h11);
    chk("rst_br_b", br_b, 32'h22);
    chk("rst_stall", {31'd0, load_use_stall}, 32'd0);
    tick();
    RESET = 1'b1;
    tick();
    chk("post_rst_exe_a", exe_a, 32'h11);

    // ALU forward through all three slots
    EXE_B_Select = 0; Branch_JR_select_A = 0; Branch_JR_select_B = 0;
    advance = 1; result_valid = 1; result_reg = 5; result_data = 32'hDEAD;
    tick();
    advance = 0; result_valid = 0; result_data = 32'h5555;
    #1 chk("alu_s1", exe_a, 32'hDEAD);
    EXE_A_Select = 2;
    #1 chk("alu_s2_empty", exe_a, 32'h11);
    advance = 1;
    tick(); tick();
    advance = 0;
    EXE_A_Select = 3;
    #1 chk("alu_s3", exe_a, 32'hDEAD);
    EXE_A_Select = 2;
    #1 chk("nowr_s2", exe_a, 32'h11);

    // destination r0 is not forwarded
    advance = 1; result_valid = 1; result_reg = 0; result_data = 32'h1234;
    tick();
    advance = 0; result_valid = 0;
    EXE_B_Select = 1; regB_in = 32'h7;
    #1 chk("r0_exe_b", exe_b, 32'h7);
    EXE_A_Select = 3;
    #1 chk("shift_out_s3", exe_a, 32'h11);
    EXE_B_Select = 0; EXE_A_Select = 0; regB_in = 32'h22;

    // load-use stall and same-cycle patch
    advance = 1; result_valid = 1; result_reg = 8; result_is_load = 1; result_data = 32'hBAD0;
    tick();
    advance = 0; result_valid = 0; result_is_load = 0;
    Branch_JR_select_A = 1;
    #1 chk("lu_stall", {31'd0, load_use_stall}, 32'd1);
    chk("lu_br_a_raw", br_a, 32'hBAD0);
    tick();
    chk("lu_stall_hold", {31'd0, load_use_stall}, 32'd1);
    load_data_valid = 1; load_data = 32'hCAFE;
    #1 chk("patch_stall", {31'd0, load_use_stall}, 32'd0);
    chk("patch_br_a", br_a, 32'hCAFE);
    advance = 1;
    tick();
    advance = 0; load_data_valid = 0;
    Branch_JR_select_A = 2;
    #1 chk("patch_s2_data", br_a, 32'hCAFE);
    chk("patch_s2_nostall", {31'd0, load_use_stall}, 32'd0);
    Branch_JR_select_A = 0;

    // hold: slots frozen while new-entry inputs and stray load data toggle
    result_valid = 1; result_reg = 3; result_data = 32'hFFFF;
    load_data_valid = 1; load_data = 32'h1357;
    EXE_A_Select = 2;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_s2", exe_a, 32'hCAFE);
      tick();
    end
    load_data_valid = 0;

    // stray load data does not overwrite a non-pending slot 1
    advance = 1; result_valid = 1; result_reg = 6; result_data = 32'h6666;
    tick();
    advance = 0; result_valid = 0;
    EXE_A_Select = 1; load_data_valid = 1; load_data = 32'h7777;
    #1 chk("ignore_ld", exe_a, 32'h6666);
    load_data_valid = 0;

    // flush with advance inserts a bubble; slots 2/3 still shift
    flush = 1; advance = 1; result_valid = 1; result_reg = 9; result_data = 32'h9999;
    tick();
    advance = 0; result_valid = 0;
    #1 chk("flush_s1", exe_a, 32'h11);
    EXE_A_Select = 2;
    #1 chk("flush_s2", exe_a, 32'h6666);
    EXE_A_Select = 3;
    #1 chk("flush_s3", exe_a, 32'h11);
    tick();
    EXE_A_Select = 2;
    #1 chk("flush_noadv_s2", exe_a, 32'h6666);
    flush = 0; EXE_A_Select = 0;

    // unpatched load shifted to slot 2 stays pending
    advance = 1; result_valid = 1; result_reg = 10; result_is_load = 1; result_data = 32'h0;
    tick();
    result_valid = 0; result_is_load = 0;
    tick();
    advance = 0;
    EXE_B_Select = 2;
    #1 chk("s2_pend_stall", {31'd0, load_use_stall}, 32'd1);
    load_data_valid = 1; load_data = 32'hAAAA;
    #1 chk("s2_no_patch", {31'd0, load_use_stall}, 32'd1);
    load_data_valid = 0;

    // async reset mid-stall
    #2 RESET = 1'b0;
    #1 chk("rst_mid_stall", {31'd0, load_use_stall}, 32'd0);
    chk("rst_mid_exe_b", exe_b, 32'h22);
    tick();
    RESET = 1'b1;
    tick();
    chk("post_rst2_stall", {31'd0, load_use_stall}, 32'd0);
    chk("post_rst2_exe_b", exe_b, 32'h22);

    // a load into r0 never stalls
    advance = 1; result_valid = 1; result_reg = 0; result_is_load = 1; result_data = 32'h4444;
    tick();
    advance = 0; result_valid = 0; result_is_load = 0;
    EXE_B_Select = 1;
    #1 chk("r0_load_nostall", {31'd0, load_use_stall}, 32'd0);
    chk("r0_load_exe_b", exe_b, 32'h22);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
